instruction_mem_pipelined: RTL and testbench

- Parametrised instruction memory. Word width, depth and address-to-word shift are configurable, and read latency is programmable.
- Two independent ports:
  - Fetch read port with a request/valid handshake.
  - Program-load write port.
- Adds out-of-range detection, deterministic write/read collision behaviour and an optional zero-fill sequencer after reset.
- Sits between the control unit's fetch stage and the instruction register. The loader/testbench drives the write port.

---
 rtl/instruction_mem_pipelined.sv | 117 +++++++++++
 tb/tb_instruction_mem_pipelined.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_mem_pipelined.sv
// Instruction memory with a pipelined fetch port, a program-load write port,
// out-of-range flagging, write-first collision bypass and optional zero-fill after reset.
module instruction_mem_pipelined #(
    parameter int INSTRUCTION_WIDTH = 19,
    parameter int ADDRESS_BUS_WIDTH = 10,
    parameter int DEPTH             = 128,
    parameter int ADDR_SHIFT        = 2,
    parameter int READ_LATENCY      = 1,
    parameter bit CLEAR_ON_RESET    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] rd_addr,
    output logic                         rd_valid,
    output logic [INSTRUCTION_WIDTH-1:0] rd_data,
    output logic                         rd_err,
    input  logic                         wr_en,
    input  logic [ADDRESS_BUS_WIDTH-1:0] wr_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         wr_err,
    output logic                         init_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               fill_cnt;
    logic [INSTRUCTION_WIDTH-1:0]   mem [DEPTH];

    logic [ADDRESS_BUS_WIDTH-1:0]   rd_idx;
    logic [ADDRESS_BUS_WIDTH-1:0]   wr_idx;
    logic                           rd_in_range;
    logic                           wr_in_range;
    logic                           rd_accept;
    logic                           wr_accept;
    logic                           wr_hit;
    logic [INSTRUCTION_WIDTH-1:0]   rd_word;

    logic [READ_LATENCY-1:0]        pipe_valid;
    logic [READ_LATENCY-1:0]        pipe_err;
    logic [INSTRUCTION_WIDTH-1:0]   pipe_data [READ_LATENCY];

    assign rd_idx      = rd_addr >> ADDR_SHIFT;
    assign wr_idx      = wr_addr >> ADDR_SHIFT;
    assign rd_in_range = int'(rd_idx) < DEPTH;
    assign wr_in_range = int'(wr_idx) < DEPTH;
    assign rd_accept   = rd_req && !init_busy;
    assign wr_accept   = wr_en && !init_busy;
    assign wr_hit      = wr_accept && wr_in_range;

    // Same-cycle write to the fetched word is forwarded so the read sees the new value.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_hit && (wr_idx == rd_idx))
                rd_word = wr_data;
            else
                rd_word = mem[rd_idx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? INIT : READY;
            init_busy <= CLEAR_ON_RESET;
            fill_cnt  <= '0;
        end else if (state == INIT) begin
            fill_cnt <= fill_cnt + IDX_W'(1);
            if (fill_cnt == IDX_W'(DEPTH - 1)) begin
                state     <= READY;
                init_busy <= 1'b0;
            end
        end
    end

    // The array has no reset; zero-fill and program loads share the one write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[fill_cnt] <= '0;
            else if (wr_hit)
                mem[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            wr_err     <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++)
                pipe_data[i] <= '0;
        end else begin
            pipe_valid <= (pipe_valid << 1) | READ_LATENCY'(rd_accept);
            // Stages only load on a valid token, so the last stage holds its value between reads.
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_err[i]  <= pipe_err[i-1];
                end
            end
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
                pipe_err[0]  <= !rd_in_range;
            end
            wr_err <= wr_accept && !wr_in_range;
        end
    end

    assign rd_valid = pipe_valid[READ_LATENCY-1];
    assign rd_data  = pipe_data[READ_LATENCY-1];
    assign rd_err   = pipe_err[READ_LATENCY-1];

endmodule

// File: tb/tb_instruction_mem_pipelined.sv
// Scoreboard bench: dut_a (latency 2, zero-fill) and dut_b (latency 3, contents kept)
// share the port inputs but have separate resets so only one is active at a time.
module tb_instruction_mem_pipelined;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        rd_req = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [18:0] wr_data = '0;

    logic        rd_valid_a, rd_err_a, wr_err_a, init_busy_a;
    logic [18:0] rd_data_a;
    logic        rd_valid_b, rd_err_b, wr_err_b, init_busy_b;
    logic [18:0] rd_data_b;

    typedef struct {
        logic [18:0] data;
        logic        err;
        int          cyc;
        bit          dut;
    } exp_t;

    exp_t        sb[$];
    logic [18:0] model [128];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          active_b = 1'b0;

    instruction_mem_pipelined #(.READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_err(rd_err_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err_a), .init_busy(init_busy_a)
    );

    instruction_mem_pipelined #(.READ_LATENCY(3), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_err(rd_err_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err_b), .init_busy(init_busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_rsp(input bit dut, input logic [18:0] data, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_rd_valid dut%0d: got rd_valid=1 at cycle %0d, expected 0", dut, cyc);
        end else begin
            e = sb.pop_front();
            check_output("rsp_dut", 32'(dut), 32'(e.dut));
            check_output("rd_data", 32'(data), 32'(e.data));
            check_output("rd_err", 32'(err), 32'(e.err));
            check_output("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: every rd_valid from either DUT must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid_a === 1'b1) check_rsp(1'b0, rd_data_a, rd_err_a);
            if (rd_valid_b === 1'b1) check_rsp(1'b1, rd_data_b, rd_err_b);
        end
    end

    task automatic apply_stimulus(input bit do_rd, input logic [9:0] ra, input bit push,
                                  input logic [18:0] exp_data, input logic exp_err,
                                  input bit do_wr, input logic [9:0] wa, input logic [18:0] wd);
        exp_t e;
        rd_req  = do_rd;
        rd_addr = ra;
        wr_en   = do_wr;
        wr_addr = wa;
        wr_data = wd;
        if (do_rd && push) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.cyc  = cyc + (active_b ? 3 : 2);
            e.dut  = active_b;
            sb.push_back(e);
        end
        if (do_wr && !active_b && (wa >> 2) < 10'd128)
            model[wa[8:2]] = wd;
        @(negedge clk);
        rd_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [18:0] d, input logic e);
        apply_stimulus(1'b1, a, 1'b1, d, e, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [18:0] d);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_a(input int cycles);
        @(negedge clk);
        rst_a  = 1'b1;
        rd_req = 1'b0;
        wr_en  = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 128; i++) model[i] = '0;
    endtask

    // Counts negedges with init_busy high from reset release; optionally pokes both ports meanwhile.
    task automatic count_busy(input bit poke, output int n, output bit saw_wr_err);
        n = 0;
        saw_wr_err = 1'b0;
        while (init_busy_a === 1'b1 && n < 400) begin
            if (wr_err_a === 1'b1) saw_wr_err = 1'b1;
            rd_req  = poke && (n < 5);
            rd_addr = '0;
            wr_en   = poke && (n < 5);
            wr_addr = (n == 4) ? 10'h3FC : 10'h000;
            wr_data = 19'h1FFFF;
            n++;
            @(negedge clk);
        end
        if (wr_err_a === 1'b1) saw_wr_err = 1'b1;
        rd_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    initial begin
        int  busy_cycles;
        bit  saw_wr_err;

        reset_a(2);
        check_output("reset_rd_valid", 32'(rd_valid_a), 32'd0);
        check_output("reset_rd_data", 32'(rd_data_a), 32'd0);
        check_output("reset_rd_err", 32'(rd_err_a), 32'd0);
        check_output("reset_wr_err", 32'(wr_err_a), 32'd0);
        check_output("reset_init_busy", 32'(init_busy_a), 32'd1);

        count_busy(1'b1, busy_cycles, saw_wr_err);
        check_output("init_busy_cycles", 32'(busy_cycles), 32'd128);
        check_output("wr_err_during_init", 32'(saw_wr_err), 32'd0);

        rd(10'h000, 19'h00000, 1'b0);
        rd(10'h07C, 19'h00000, 1'b0);
        idle(4);

        wr(10'h000, 19'h20110);
        wr(10'h004, 19'h20220);
        wr(10'h008, 19'h07600);
        wr(10'h00C, 19'h24330);
        rd(10'h000, 19'h20110, 1'b0);
        rd(10'h004, 19'h20220, 1'b0);
        rd(10'h008, 19'h07600, 1'b0);
        rd(10'h00C, 19'h24330, 1'b0);
        rd(10'h006, 19'h20220, 1'b0);
        idle(4);

        rd(10'h200, 19'h00000, 1'b1);
        wr(10'h3FC, 19'h15555);
        check_output("wr_err_pulse", 32'(wr_err_a), 32'd1);
        idle(1);
        check_output("wr_err_clears", 32'(wr_err_a), 32'd0);
        for (int i = 0; i < 128; i++)
            rd(10'(i * 4), model[i], 1'b0);
        idle(4);

        apply_stimulus(1'b1, 10'h010, 1'b1, 19'h1ABCD, 1'b0, 1'b1, 10'h010, 19'h1ABCD);
        rd(10'h010, 19'h1ABCD, 1'b0);
        idle(4);

        reset_a(2);
        idle(50);
        reset_a(1);
        count_busy(1'b0, busy_cycles, saw_wr_err);
        check_output("init_busy_after_midfill_reset", 32'(busy_cycles), 32'd128);
        rd(10'h000, 19'h00000, 1'b0);
        rd(10'h010, 19'h00000, 1'b0);
        idle(4);

        // Switch to dut_b: contents survive reset, in-flight reads are dropped.
        rst_a    = 1'b1;
        active_b = 1'b1;
        rst_b    = 1'b0;
        idle(1);
        check_output("b_init_busy", 32'(init_busy_b), 32'd0);
        wr(10'h004, 19'h0ABCD);
        rd(10'h004, 19'h0ABCD, 1'b0);
        idle(5);
        apply_stimulus(1'b1, 10'h004, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 10'h004, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst_b = 1'b1;
        idle(3);
        rst_b = 1'b0;
        idle(2);
        rd(10'h004, 19'h0ABCD, 1'b0);
        idle(8);

        check_output("missing_rd_valid", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
